arp_reply_gen: RTL and testbench



---
 rtl/arp_reply_gen_pkg.sv | 57 +++++
 rtl/arp_req_parse.sv | 85 ++++++++
 rtl/arp_reply_gen.sv | 124 ++++++++++++
 tb/tb_arp_reply_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/arp_reply_gen_pkg.sv
// Shared constants, FSM state type and reply byte builder for the ARP responder.
package arp_reply_gen_pkg;

    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IP  = 16'h0800;
    localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
    localparam logic [15:0] ARP_OP_REP    = 16'h0002;
    localparam logic [7:0]  ARP_HLEN_ETH  = 8'h06;
    localparam logic [7:0]  ARP_PLEN_IP   = 8'h04;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } arp_state_e;

    // Byte idx of the reply frame; everything past the ARP payload is zero pad.
    function automatic logic [7:0] reply_byte(
        input int unsigned idx,
        input logic [47:0] smac,
        input logic [31:0] sip,
        input logic [47:0] lmac,
        input logic [31:0] lip
    );
        logic [7:0] b;
        b = 8'h00;
        if (idx <= 5) begin
            b = 8'(smac >> (8 * (5 - idx)));
        end else if (idx <= 11) begin
            b = 8'(lmac >> (8 * (11 - idx)));
        end else if (idx <= 21) begin
            case (idx)
                12: b = ETH_TYPE_ARP[15:8];
                13: b = ETH_TYPE_ARP[7:0];
                14: b = ARP_HTYPE_ETH[15:8];
                15: b = ARP_HTYPE_ETH[7:0];
                16: b = ARP_PTYPE_IP[15:8];
                17: b = ARP_PTYPE_IP[7:0];
                18: b = ARP_HLEN_ETH;
                19: b = ARP_PLEN_IP;
                20: b = ARP_OP_REP[15:8];
                default: b = ARP_OP_REP[7:0];
            endcase
        end else if (idx <= 27) begin
            b = 8'(lmac >> (8 * (27 - idx)));
        end else if (idx <= 31) begin
            b = 8'(lip >> (8 * (31 - idx)));
        end else if (idx <= 37) begin
            b = 8'(smac >> (8 * (37 - idx)));
        end else if (idx <= 41) begin
            b = 8'(sip >> (8 * (41 - idx)));
        end
        return b;
    endfunction

endpackage

// File: rtl/arp_req_parse.sv
// Parses received frames for ARP requests aimed at the local IP; pulses o_req_valid once per hit.
module arp_req_parse
    import arp_reply_gen_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_local_ip,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_data_valid,
    output logic        o_req_valid,
    output logic [47:0] o_sender_mac,
    output logic [31:0] o_sender_ip
);

    logic [5:0]  r_idx;
    logic        r_prev_valid;
    logic        r_armed;
    logic        r_ok;
    logic        r_req;
    logic [47:0] r_smac;
    logic [31:0] r_sip;
    logic        w_field_ok;

    always_comb begin
        w_field_ok = 1'b1;
        case (r_idx)
            6'd12: w_field_ok = (i_rx_data == ETH_TYPE_ARP[15:8]);
            6'd13: w_field_ok = (i_rx_data == ETH_TYPE_ARP[7:0]);
            6'd14: w_field_ok = (i_rx_data == ARP_HTYPE_ETH[15:8]);
            6'd15: w_field_ok = (i_rx_data == ARP_HTYPE_ETH[7:0]);
            6'd16: w_field_ok = (i_rx_data == ARP_PTYPE_IP[15:8]);
            6'd17: w_field_ok = (i_rx_data == ARP_PTYPE_IP[7:0]);
            6'd18: w_field_ok = (i_rx_data == ARP_HLEN_ETH);
            6'd19: w_field_ok = (i_rx_data == ARP_PLEN_IP);
            6'd20: w_field_ok = (i_rx_data == ARP_OP_REQ[15:8]);
            6'd21: w_field_ok = (i_rx_data == ARP_OP_REQ[7:0]);
            6'd38: w_field_ok = (i_rx_data == i_local_ip[31:24]);
            6'd39: w_field_ok = (i_rx_data == i_local_ip[23:16]);
            6'd40: w_field_ok = (i_rx_data == i_local_ip[15:8]);
            6'd41: w_field_ok = (i_rx_data == i_local_ip[7:0]);
            default: ;
        endcase
    end

    // r_armed stays low after reset until the line goes idle, so a frame cut by reset is ignored.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx        <= '0;
            r_prev_valid <= 1'b0;
            r_armed      <= 1'b0;
            r_ok         <= 1'b0;
            r_req        <= 1'b0;
            r_smac       <= '0;
            r_sip        <= '0;
        end else begin
            r_prev_valid <= i_rx_data_valid;
            r_req        <= 1'b0;
            if (i_rx_data_valid) begin
                if (r_armed) begin
                    if (r_idx != 6'd63) begin
                        r_idx <= r_idx + 6'd1;
                    end
                    r_ok <= ((r_idx == 6'd0) ? 1'b1 : r_ok) & w_field_ok;
                    if (r_idx >= 6'd22 && r_idx <= 6'd27) begin
                        r_smac <= {r_smac[39:0], i_rx_data};
                    end
                    if (r_idx >= 6'd28 && r_idx <= 6'd31) begin
                        r_sip <= {r_sip[23:0], i_rx_data};
                    end
                end
            end else begin
                r_armed <= 1'b1;
                r_idx   <= '0;
                if (r_prev_valid && r_armed && r_ok && r_idx >= 6'd42) begin
                    r_req <= 1'b1;
                end
            end
        end
    end

    assign o_req_valid  = r_req;
    assign o_sender_mac = r_smac;
    assign o_sender_ip  = r_sip;

endmodule

// File: rtl/arp_reply_gen.sv
// ARP responder for one port: turns valid requests into padded reply frames with a forced gap.
module arp_reply_gen
    import arp_reply_gen_pkg::*;
#(
    parameter int unsigned FRAME_LEN  = 60,
    parameter int unsigned GAP_CYCLES = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_local_ip,
    input  logic [47:0] i_local_mac,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_data_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_data_valid,
    output logic [15:0] o_reply_cnt,
    output logic [15:0] o_drop_cnt
);

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);
    localparam logic [7:0]  GAP_LAST = 8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    arp_state_e  r_state;
    logic [15:0] r_cnt;
    logic [7:0]  r_gap;
    logic [47:0] r_send_mac;
    logic [31:0] r_send_ip;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic [15:0] r_reply_cnt;
    logic [15:0] r_drop_cnt;

    logic        w_req_valid;
    logic [47:0] w_hold_mac;
    logic [31:0] w_hold_ip;
    int unsigned w_byte_idx;
    logic [47:0] w_src_mac;
    logic [31:0] w_src_ip;
    logic [7:0]  w_next_byte;

    arp_req_parse u_parse (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_local_ip      (i_local_ip),
        .i_rx_data       (i_rx_data),
        .i_rx_data_valid (i_rx_data_valid),
        .o_req_valid     (w_req_valid),
        .o_sender_mac    (w_hold_mac),
        .o_sender_ip     (w_hold_ip)
    );

    // Byte 0 is built straight from the holding register; the send copy lands on the same edge.
    always_comb begin
        w_byte_idx = 0;
        w_src_mac  = w_hold_mac;
        w_src_ip   = w_hold_ip;
        if (r_state != StIdle) begin
            w_byte_idx = 32'(r_cnt) + 32'd1;
            w_src_mac  = r_send_mac;
            w_src_ip   = r_send_ip;
        end
        w_next_byte = reply_byte(w_byte_idx, w_src_mac, w_src_ip, i_local_mac, i_local_ip);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_gap       <= '0;
            r_send_mac  <= '0;
            r_send_ip   <= '0;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_reply_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_req_valid && r_state != StIdle) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            case (r_state)
                StIdle: begin
                    r_tx_data  <= 8'h00;
                    r_tx_valid <= 1'b0;
                    if (w_req_valid) begin
                        r_state    <= StSend;
                        r_send_mac <= w_hold_mac;
                        r_send_ip  <= w_hold_ip;
                        r_cnt      <= '0;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= w_next_byte;
                    end
                end
                StSend: begin
                    if (r_cnt == LAST_IDX) begin
                        r_tx_valid <= 1'b0;
                        r_tx_data  <= 8'h00;
                        r_gap      <= '0;
                        r_state    <= (GAP_CYCLES == 0) ? StIdle : StGap;
                    end else begin
                        r_cnt     <= r_cnt + 16'd1;
                        r_tx_data <= w_next_byte;
                        if (r_cnt + 16'd1 == LAST_IDX) begin
                            r_reply_cnt <= r_reply_cnt + 16'd1;
                        end
                    end
                end
                StGap: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= StIdle;
                    end else begin
                        r_gap <= r_gap + 8'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_tx_data       = r_tx_data;
    assign o_tx_data_valid = r_tx_valid;
    assign o_reply_cnt     = r_reply_cnt;
    assign o_drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_arp_reply_gen.sv
// Directed bench for arp_reply_gen: reply contents/latency, filtering, drops, gap, reset, wrap.
module tb_arp_reply_gen;

    localparam int unsigned FRAME_LEN  = 60;
    localparam int unsigned GAP_CYCLES = 12;
    localparam logic [47:0] LMAC = 48'h02ABCDEF0123;
    localparam logic [31:0] LIP  = 32'hC0A80164;
    localparam logic [47:0] SMAC = 48'h001122334455;
    localparam logic [31:0] SIP  = 32'hC0A80109;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [15:0] reply_cnt;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    arp_reply_gen #(
        .FRAME_LEN  (FRAME_LEN),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_local_ip      (LIP),
        .i_local_mac     (LMAC),
        .i_rx_data       (rx_data),
        .i_rx_data_valid (rx_valid),
        .o_tx_data       (tx_data),
        .o_tx_data_valid (tx_valid),
        .o_reply_cnt     (reply_cnt),
        .o_drop_cnt      (drop_cnt)
    );

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_vcyc = 0;
    int n_idle_bad = 0;
    int last_v = 0;
    int min_gap = 999;
    logic prev_v = 1'b0;
    logic have_last = 1'b0;
    logic [7:0] fr [0:63];
    logic [7:0] exp_b [0:FRAME_LEN-1];
    logic [0:41][7:0] hdr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Every cycle passes through here, so tx activity and inter-reply gaps are tracked in one place.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (tx_valid) begin
            if (!prev_v && have_last && (cyc - last_v - 1) < min_gap) min_gap = cyc - last_v - 1;
            n_vcyc++;
            last_v = cyc;
            have_last = 1'b1;
        end else if (tx_data != 8'h00) begin
            n_idle_bad++;
        end
        prev_v = tx_valid;
    endtask

    task automatic build(input logic [31:0] tip, input logic [15:0] op, input logic [15:0] etype);
        logic [0:41][7:0] h;
        h = {48'hFFFFFFFFFFFF, SMAC, etype, 16'h0001, 16'h0800, 8'h06, 8'h04, op,
             SMAC, SIP, 48'h0, tip};
        for (int i = 0; i < 64; i++) fr[i] = (i < 42) ? h[i] : 8'h00;
    endtask

    task automatic drive(input int len);
        for (int i = 0; i < len; i++) begin
            tick();
            rx_valid = 1'b1;
            rx_data  = fr[i];
        end
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic check_reply(input string tag);
        int k;
        k = 0;
        while (!tx_valid && k < 10) begin
            tick();
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'd2);
        for (int i = 0; i < int'(FRAME_LEN); i++) begin
            if (i > 0) tick();
            chk($sformatf("%s byte%0d", tag, i), 32'({tx_valid, tx_data}), 32'({1'b1, exp_b[i]}));
        end
        tick();
        chk({tag, " end"}, 32'({tx_valid, tx_data}), 32'd0);
    endtask

    initial begin
        hdr = {SMAC, LMAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
               LMAC, LIP, SMAC, SIP};
        for (int i = 0; i < int'(FRAME_LEN); i++) exp_b[i] = (i < 42) ? hdr[i] : 8'h00;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (3) tick();
        chk("reset out", 32'({tx_valid, tx_data}), 32'd0);
        chk("reset reply_cnt", 32'(reply_cnt), 32'd0);
        chk("reset drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // 1: basic request
        build(LIP, 16'h0001, 16'h0806);
        drive(60);
        check_reply("t1");
        chk("t1 reply_cnt", 32'(reply_cnt), 32'd1);
        chk("t1 drop_cnt", 32'(drop_cnt), 32'd0);

        // 2: wrong target IP, reply opcode, non-ARP ethertype
        n_vcyc = 0;
        build(32'hC0A80165, 16'h0001, 16'h0806);
        drive(60);
        repeat (6) tick();
        build(LIP, 16'h0002, 16'h0806);
        drive(60);
        repeat (6) tick();
        build(LIP, 16'h0001, 16'h0800);
        drive(60);
        repeat (6) tick();
        chk("t2 no tx", 32'(n_vcyc), 32'd0);
        chk("t2 reply_cnt", 32'(reply_cnt), 32'd1);
        chk("t2 drop_cnt", 32'(drop_cnt), 32'd0);

        // 3: truncated frame, then long padded frame
        build(LIP, 16'h0001, 16'h0806);
        drive(41);
        repeat (6) tick();
        chk("t3 short no tx", 32'(n_vcyc), 32'd0);
        chk("t3 short reply_cnt", 32'(reply_cnt), 32'd1);
        drive(64);
        check_reply("t3");
        chk("t3 reply_cnt", 32'(reply_cnt), 32'd2);
        repeat (20) tick();

        // 4: drop during SEND, drop on the GAP->IDLE cycle, accept one cycle later
        n_vcyc = 0;
        drive(42);
        drive(42);
        repeat (40) tick();
        chk("t4 one reply", 32'(n_vcyc), 32'd60);
        chk("t4 drop send", 32'(drop_cnt), 32'd1);
        chk("t4 reply_cnt a", 32'(reply_cnt), 32'd3);
        n_vcyc = 0;
        drive(42);
        repeat (29) tick();
        drive(42);
        repeat (80) tick();
        chk("t4 gap edge replies", 32'(n_vcyc), 32'd60);
        chk("t4 drop gap edge", 32'(drop_cnt), 32'd2);
        chk("t4 reply_cnt b", 32'(reply_cnt), 32'd4);
        n_vcyc = 0;
        have_last = 1'b0;
        min_gap = 999;
        drive(42);
        repeat (30) tick();
        drive(42);
        repeat (100) tick();
        chk("t4 back-to-back replies", 32'(n_vcyc), 32'd120);
        chk("t4 reply_cnt c", 32'(reply_cnt), 32'd6);
        chk("t4 drop_cnt c", 32'(drop_cnt), 32'd2);
        chk("t4 min gap ok", 32'(min_gap >= int'(GAP_CYCLES)), 32'd1);

        // 5: reset mid-reply, reset mid-rx-frame, then a clean reply
        drive(42);
        repeat (32) tick();
        chk("t5 byte30", 32'({tx_valid, tx_data}), 32'({1'b1, exp_b[30]}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5 rst out", 32'({tx_valid, tx_data}), 32'd0);
        chk("t5 rst reply_cnt", 32'(reply_cnt), 32'd0);
        chk("t5 rst drop_cnt", 32'(drop_cnt), 32'd0);
        repeat (3) tick();
        n_vcyc = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            rx_valid = 1'b1;
            rx_data  = fr[i];
            rst      = (i == 20);
        end
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst      = 1'b0;
        repeat (8) tick();
        chk("t5 cut frame no tx", 32'(n_vcyc), 32'd0);
        drive(42);
        check_reply("t5");
        chk("t5 reply_cnt", 32'(reply_cnt), 32'd1);
        repeat (15) tick();

        // 6: reply counter wrap
        force dut.r_reply_cnt = 16'hFFFE;
        tick();
        release dut.r_reply_cnt;
        drive(42);
        check_reply("t6a");
        chk("t6 reply_cnt ffff", 32'(reply_cnt), 32'h0000FFFF);
        repeat (15) tick();
        drive(42);
        check_reply("t6b");
        chk("t6 reply_cnt wrap", 32'(reply_cnt), 32'd0);

        chk("idle tx_data zero", 32'(n_idle_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
